// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle LEGv8 main control unit.
// Holds the FSM state enum, the opcode class enum, the casez opcode patterns
// and the datapath select encodings used by the top and by opclass_dec.
package multicycle_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned OPC_W   = 11;

   typedef enum logic [STATE_W-1:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      EXEC_I   = 4'd3,
      WB_ALU   = 4'd4,
      MEM_ADDR = 4'd5,
      MEM_RD   = 4'd6,
      MEM_WR   = 4'd7,
      WB_MEM   = 4'd8,
      BRANCH   = 4'd9,
      JUMP     = 4'd10,
      HALT     = 4'd11
   } state_t;

   typedef enum logic [2:0] {
      OC_ILLEGAL = 3'd0,
      OC_R       = 3'd1,
      OC_IMM     = 3'd2,
      OC_LDUR    = 3'd3,
      OC_STUR    = 3'd4,
      OC_CBZ     = 3'd5,
      OC_CBNZ    = 3'd6,
      OC_B       = 3'd7
   } op_class_t;

   // Opcode patterns; '?' bits are don't-care in casez
   localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
   localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;
   localparam logic [OPC_W-1:0] OPC_R    = 11'b1??0101?000;
   localparam logic [OPC_W-1:0] OPC_CBZ  = 11'b10110100???;
   localparam logic [OPC_W-1:0] OPC_CBNZ = 11'b10110101???;
   localparam logic [OPC_W-1:0] OPC_ADDI = 11'b1001000100?;
   localparam logic [OPC_W-1:0] OPC_SUBI = 11'b1101000100?;
   localparam logic [OPC_W-1:0] OPC_B    = 11'b000101?????;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_PASSB = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_PC4 = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_B   = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_maindec_opclass_dec.sv
// Combinational opcode classifier: Op -> op_class_t.
// Ports: op_i (opcode field), class_o (decoded class; OC_ILLEGAL if unknown).
// With EXT_EN=0 only R-format/LDUR/STUR/CBZ are recognised.
module opclass_dec
   import multicycle_pkg::*;
#(
   parameter int unsigned OP_W   = 11,
   parameter bit          EXT_EN = 1'b1
) (
   input  logic [OP_W-1:0] op_i,
   output op_class_t       class_o
);

   always_comb begin
      class_o = OC_ILLEGAL;
      casez (op_i)
         OPC_LDUR:           class_o = OC_LDUR;
         OPC_STUR:           class_o = OC_STUR;
         OPC_R:              class_o = OC_R;
         OPC_CBZ:            class_o = OC_CBZ;
         OPC_CBNZ:           if (EXT_EN) class_o = OC_CBNZ;
         OPC_ADDI, OPC_SUBI: if (EXT_EN) class_o = OC_IMM;
         OPC_B:              if (EXT_EN) class_o = OC_B;
         default:            class_o = OC_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_maindec.sv
// Multi-cycle LEGv8 main control unit.
// Inputs : clk, reset (sync, active-low), Op (opcode, used in DECODE),
//          zero (ALU flag, used in BRANCH), mem_ready (memory handshake).
// Outputs: datapath enables/selects decoded from the current state, sticky
//          illegal/timeout flags and state_o for debug.
module multicycle_maindec
   import multicycle_pkg::*;
#(
   parameter int unsigned OP_W     = 11,
   parameter bit          EXT_EN   = 1'b1,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [OP_W-1:0] Op,
   input  logic            zero,
   input  logic            mem_ready,
   output logic            mem_req,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            IorD,
   output logic            IRWrite,
   output logic            PCWrite,
   output logic [1:0]      PCSrc,
   output logic            Reg2Loc,
   output logic [1:0]      ALUSrcB,
   output logic [1:0]      ALUOp,
   output logic            MemtoReg,
   output logic            RegWrite,
   output logic            illegal,
   output logic            timeout,
   output logic [3:0]      state_o
);

   localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

   state_t           state_q, state_d;
   op_class_t        class_q, class_d, class_c;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             timeout_q, timeout_d;
   logic             req_c;
   logic             wait_hit_c;

   opclass_dec #(.OP_W(OP_W), .EXT_EN(EXT_EN)) u_opclass_dec (
      .op_i    (Op),
      .class_o (class_c)
   );

   assign req_c      = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
   assign wait_hit_c = req_c && !mem_ready && (cnt_q == CNT_W'(MAX_WAIT));
   assign state_o    = state_q;

   // Next state, wait counter, latched class and sticky flags
   always_comb begin
      state_d   = state_q;
      class_d   = class_q;
      cnt_d     = '0;
      illegal_d = illegal_q;
      timeout_d = timeout_q;

      if (req_c && !mem_ready) begin
         if (wait_hit_c) begin
            timeout_d = 1'b1;
            state_d   = HALT;
         end else begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
         end
      end

      case (state_q)
         FETCH:    if (mem_ready) state_d = DECODE;
         DECODE: begin
            class_d = class_c;
            case (class_c)
               OC_LDUR, OC_STUR: state_d = MEM_ADDR;
               OC_R:             state_d = EXEC_R;
               OC_IMM:           state_d = EXEC_I;
               OC_CBZ, OC_CBNZ:  state_d = BRANCH;
               OC_B:             state_d = JUMP;
               default: begin
                  state_d   = HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         EXEC_R, EXEC_I:        state_d = WB_ALU;
         WB_ALU, WB_MEM:        state_d = FETCH;
         MEM_ADDR:              state_d = (class_q == OC_STUR) ? MEM_WR : MEM_RD;
         MEM_RD:   if (mem_ready) state_d = WB_MEM;
         MEM_WR:   if (mem_ready) state_d = FETCH;
         BRANCH, JUMP:          state_d = FETCH;
         HALT:                  state_d = HALT;
         default:               state_d = HALT;
      endcase
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= FETCH;
         class_q   <= OC_ILLEGAL;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

   // Datapath controls decoded from state; FETCH/MEM handshakes and the
   // branch decision also look at mem_ready/zero in the same cycle.
   always_comb begin
      mem_req  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = PCSRC_PC4;
      Reg2Loc  = 1'b0;
      ALUSrcB  = SRCB_REG;
      ALUOp    = ALUOP_ADD;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      illegal  = illegal_q;
      timeout  = timeout_q;

      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         EXEC_R: ALUOp = ALUOP_FUNCT;
         EXEC_I: begin
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_FUNCT;
         end
         WB_ALU: RegWrite = 1'b1;
         MEM_ADDR: begin
            ALUSrcB = SRCB_IMM;
            Reg2Loc = (class_q == OC_STUR);
         end
         MEM_RD: begin
            mem_req = 1'b1;
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         MEM_WR: begin
            mem_req  = 1'b1;
            MemWrite = 1'b1;
            IorD     = 1'b1;
            Reg2Loc  = 1'b1;
         end
         WB_MEM: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         BRANCH: begin
            Reg2Loc = 1'b1;
            ALUOp   = ALUOP_PASSB;
            PCSrc   = PCSRC_BR;
            PCWrite = ((class_q == OC_CBZ) && zero) || ((class_q == OC_CBNZ) && !zero);
         end
         JUMP: begin
            PCWrite = 1'b1;
            PCSrc   = PCSRC_B;
         end
         default: ;
      endcase

      // While reset is held, present a quiet fetch with no enables
      if (!reset) begin
         mem_req  = 1'b1;
         MemRead  = 1'b1;
         MemWrite = 1'b0;
         IorD     = 1'b0;
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         PCSrc    = PCSRC_PC4;
         Reg2Loc  = 1'b0;
         ALUSrcB  = SRCB_REG;
         ALUOp    = ALUOP_ADD;
         MemtoReg = 1'b0;
         RegWrite = 1'b0;
         illegal  = 1'b0;
         timeout  = 1'b0;
      end
   end

endmodule

// File: doc/multicycle_maindec.md
Name: multicycle_maindec

Overview:
- Multi-cycle LEGv8 main control unit; successor to the single-cycle main decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives datapath enables per state.
- Handshakes with a variable-latency memory and adds ADDI/SUBI, CBNZ and B when enabled.
- Sits between the instruction register (its Op input) and the shared multi-cycle datapath.

Parameters:
- OP_W, 11, opcode field width taken from instr[31:21].
- EXT_EN, 1, 1 = decode ADDI/SUBI/CBNZ/B; 0 = only R-format/LDUR/STUR/CBZ, all others illegal.
- MAX_WAIT, 15, max cycles to wait for mem_ready before flagging timeout; counter width is $clog2(MAX_WAIT+1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low (0 = reset on next clk edge).
- Op  in  OP_W  opcode from the instruction register; sampled only in DECODE.
- zero  in  1  ALU zero flag; sampled only in BRANCH.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request active.
- MemRead  out  1  read request (fetch or LDUR).
- MemWrite  out  1  write request (STUR).
- IorD  out  1  0 = PC address, 1 = ALU address.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  unconditional PC update.
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = B target.
- Reg2Loc  out  1  1 = second read register from Rt field.
- ALUSrcB  out  2  00 = reg, 01 = constant 4, 10 = sign-ext imm/offset.
- ALUOp  out  2  00 = add, 01 = pass-B/compare, 10 = R-funct.
- MemtoReg  out  1  1 = write-back from memory data register.
- RegWrite  out  1  register-file write enable.
- illegal  out  1  sticky: unrecognised opcode.
- timeout  out  1  sticky: memory wait exceeded MAX_WAIT.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset (reset=0 at edge):
  - state = FETCH; wait counter = 0; illegal = timeout = 0.
  - All outputs are Moore, decoded from state. In FETCH they are mem_req=1, MemRead=1, IorD=0. All other control outputs read 0 during reset.
  - Reset mid-instruction abandons the instruction. No write enable may assert in the cycle after reset deasserts.
- FETCH:
  - Asserts mem_req, MemRead, IorD=0, ALUSrcB=01, ALUOp=00.
  - On mem_ready: IRWrite=1 and PCWrite=1 with PCSrc=00 in the same cycle, then go to DECODE.
- DECODE (1 cycle): classify Op with casez:
  - LDUR 11111000010 -> MEM_ADDR.
  - STUR 11111000000 -> MEM_ADDR.
  - R-format 1??0101?000 -> EXEC_R.
  - CBZ 10110100??? -> BRANCH.
  - CBNZ 10110101??? -> BRANCH (EXT_EN only).
  - ADDI 1001000100? / SUBI 1101000100? -> EXEC_I (EXT_EN only).
  - B 000101????? -> JUMP (EXT_EN only).
  - Otherwise -> HALT with illegal=1.
  - The opcode class is latched in a register held until the next DECODE.
- EXEC_R: Reg2Loc=0, ALUSrcB=00, ALUOp=10 -> WB_ALU.
- EXEC_I: ALUSrcB=10, ALUOp=10 -> WB_ALU.
- WB_ALU: RegWrite=1, MemtoReg=0 -> FETCH.
- MEM_ADDR: ALUSrcB=10, ALUOp=00, Reg2Loc=1 for STUR. LDUR -> MEM_RD, STUR -> MEM_WR.
- MEM_RD: mem_req, MemRead, IorD=1. Hold until mem_ready, then -> WB_MEM.
- WB_MEM: RegWrite=1, MemtoReg=1 -> FETCH.
- MEM_WR: mem_req, MemWrite, IorD=1, Reg2Loc=1. Hold until mem_ready, then -> FETCH.
- BRANCH: Reg2Loc=1, ALUSrcB=00, ALUOp=01, PCSrc=01.
  - PCWrite = (CBZ & zero) | (CBNZ & ~zero).
  - -> FETCH.
- JUMP: PCWrite=1, PCSrc=10 -> FETCH.
- HALT: absorbing; all enables 0; left only by reset.
- Wait counter:
  - Increments each cycle in a mem_req state while mem_ready=0; clears when leaving the state.
  - When the counter reaches MAX_WAIT with mem_ready still 0: timeout=1 and next state is HALT.
  - mem_ready=1 in the same cycle as reaching MAX_WAIT counts as success; no timeout.
- Latency, with mem_ready asserted in the first request cycle:
  - R/I: 4 cycles. LDUR: 5. STUR: 4. CBZ/CBNZ/B: 3.
- mem_req/MemRead/MemWrite stay stable while waiting. No request is issued outside the FETCH, MEM_RD and MEM_WR states.

Decomposition:
- Package multicycle_pkg holds:
  - state_t enum: FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, JUMP, HALT.
  - op_class_t enum.
  - casez opcode pattern constants.
  - Encoding constants for ALUOp, PCSrc and ALUSrcB.
- Sub-module opclass_dec: combinational Op -> op_class_t, honouring EXT_EN. It is reusable by the pipelined core.
- The FSM, wait counter and sticky flags live in the top module.

Test Plan:
- ADD (Op=10001011000), mem_ready always 1:
  - State sequence FETCH, DECODE, EXEC_R, WB_ALU, FETCH.
  - RegWrite=1 exactly in cycle 4; MemtoReg=0.
- LDUR (11111000010), mem_ready held low 3 cycles in MEM_RD:
  - MemRead/IorD=1 stable for 4 cycles.
  - WB_MEM asserts RegWrite=1 and MemtoReg=1; no timeout.
- CBZ with zero=1, then CBNZ (10110101000) with zero=1:
  - CBZ: PCWrite=1, PCSrc=01.
  - CBNZ: PCWrite=0.
  - With EXT_EN=0, CBNZ sets illegal=1 and enters HALT.
- Op=00000000000:
  - illegal=1, state HALT, all enables 0 for 20 cycles.
  - reset=0 for one edge clears illegal and returns to FETCH.
- MAX_WAIT=15, mem_ready never asserted in FETCH:
  - timeout=1 on the 16th request cycle, then HALT.
  - Repeat with mem_ready=1 exactly on the 16th request cycle: no timeout, IRWrite=1.
- reset=0 asserted during MEM_WR:
  - Next cycle state FETCH, MemWrite=0, RegWrite=0.
  - A following STUR completes normally.
